// File: rtl/axi_lite_burst_reader.sv
// rtl/axi_lite_burst_reader.sv - AXI-lite burst read initiator streaming N words out on AXI-stream
//
// axi_lite_burst_reader_fifo
//   DEPTH-entry response buffer with a registered occupancy count, so a word
//   pushed into an empty buffer becomes visible on the following cycle.
//   i_clk/i_rst clock and async reset; i_push/i_wdata write side;
//   i_pop read side; o_full/o_empty status; o_rdata head-of-queue word.
//
// axi_lite_burst_reader
//   On start, issues N AXI-lite reads at word addresses BASE..BASE+N-1
//   (modulo 2**ADDR_WIDTH), buffers the responses and forwards them in order
//   on an AXI-stream master, TLAST on the final word.
//   ap_clk/ap_rst           clock, asynchronous active-high reset
//   start/busy/done         run control and status
//   err/err_idx             sticky error flag and index of first bad response
//   m_axi_AR*, m_axi_R*     AXI-lite read master
//   m_axis_T*               AXI-stream master

module axi_lite_burst_reader_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW = $clog2(DEPTH + 1);
    localparam logic [KW-1:0] FULL_CNT = KW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [KW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A push at full is legal only when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage is not reset; the top masks the data while the buffer is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + KW'(1);
                2'b01:   r_count <= r_count - KW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module axi_lite_burst_reader #(
    parameter int N          = 9,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BASE       = 0,
    parameter int DEPTH      = 2
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] err_idx,
    output logic                                 m_axi_ARVALID,
    input  logic                                 m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0]                m_axi_ARADDR,
    input  logic                                 m_axi_RVALID,
    output logic                                 m_axi_RREADY,
    input  logic [DATA_WIDTH-1:0]                m_axi_RDATA,
    input  logic [1:0]                           m_axi_RRESP,
    output logic                                 m_axis_TVALID,
    input  logic                                 m_axis_TREADY,
    output logic [DATA_WIDTH-1:0]                m_axis_TDATA,
    output logic                                 m_axis_TLAST
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int KW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]         N_CNT      = CW'(N);
    localparam logic [CW-1:0]         LAST_IDX   = CW'(N - 1);
    localparam logic [KW-1:0]         CREDIT_MAX = KW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(BASE);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_issue_cnt;
    logic [CW-1:0]         r_recv_cnt;
    logic [CW-1:0]         r_out_cnt;
    logic [KW-1:0]         r_credit;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_err;
    logic [IW-1:0]         r_err_idx;

    logic                  w_busy;
    logic                  w_rready;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_pop;
    logic                  w_done;
    logic                  w_start;
    logic [CW-1:0]         w_issue_next;
    logic [KW-1:0]         w_credit_next;

    assign w_busy       = (r_state == S_RUN);
    // Gated by busy so RREADY sits low in reset and between runs.
    assign w_rready     = w_busy && !w_fifo_full;
    assign w_tvalid     = !w_fifo_empty;
    assign w_tlast      = w_tvalid && (r_out_cnt == LAST_IDX);
    assign w_ar_hs      = r_arvalid && m_axi_ARREADY;
    assign w_r_hs       = m_axi_RVALID && w_rready;
    assign w_pop        = w_tvalid && m_axis_TREADY;
    assign w_done       = w_pop && w_tlast;
    assign w_start      = start && !w_busy;
    assign w_issue_next = r_issue_cnt + CW'(w_ar_hs);

    // Credit counts reads that are in flight or parked in the buffer; capping
    // it at DEPTH guarantees every response has a free slot on arrival.
    always_comb begin
        w_credit_next = r_credit;
        if (w_ar_hs && !w_pop) begin
            w_credit_next = r_credit + KW'(1);
        end else if (!w_ar_hs && w_pop) begin
            w_credit_next = r_credit - KW'(1);
        end
    end

    axi_lite_burst_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_push  (w_r_hs),
        .i_wdata (m_axi_RDATA),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_rdata (w_fifo_data)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_out_cnt   <= '0;
            r_credit    <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_err       <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_RUN;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_out_cnt   <= '0;
                        r_credit    <= '0;
                        r_err       <= 1'b0;
                        r_err_idx   <= '0;
                        // Nothing issued and nothing buffered: first read can go.
                        r_arvalid   <= 1'b1;
                        r_araddr    <= BASE_ADDR;
                    end
                end
                S_RUN: begin
                    r_issue_cnt <= w_issue_next;
                    r_credit    <= w_credit_next;
                    if (w_r_hs) begin
                        r_recv_cnt <= r_recv_cnt + CW'(1);
                        if ((m_axi_RRESP != 2'b00) && !r_err) begin
                            r_err     <= 1'b1;
                            r_err_idx <= r_recv_cnt[IW-1:0];
                        end
                    end
                    if (w_pop) begin
                        r_out_cnt <= r_out_cnt + CW'(1);
                    end
                    if (w_done) begin
                        r_state   <= S_IDLE;
                        r_arvalid <= 1'b0;
                    end else if (!r_arvalid || w_ar_hs) begin
                        // A pending request holds address and valid until accepted.
                        r_arvalid <= (w_issue_next < N_CNT) && (w_credit_next < CREDIT_MAX);
                        r_araddr  <= BASE_ADDR + ADDR_WIDTH'(w_issue_next);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = w_busy;
    assign done          = w_done;
    assign err           = r_err;
    assign err_idx       = r_err_idx;
    assign m_axi_ARVALID = r_arvalid;
    assign m_axi_ARADDR  = r_araddr;
    assign m_axi_RREADY  = w_rready;
    assign m_axis_TVALID = w_tvalid;
    assign m_axis_TDATA  = w_tvalid ? w_fifo_data : '0;
    assign m_axis_TLAST  = w_tlast;
endmodule

// File: tb/tb_axi_lite_burst_reader.sv
// tb/tb_axi_lite_burst_reader.sv - scoreboard bench for axi_lite_burst_reader
module tb_axi_lite_burst_reader;
    localparam int NA = 9;
    localparam int DEPTH_A = 2;
    localparam int BASE_A = 0;
    localparam int NB = 4;
    localparam int BASE_B = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // DUT A: N=9, DEPTH=2, BASE=0
    logic        start_a, busy_a, done_a, err_a;
    logic [3:0]  err_idx_a;
    logic        arvalid_a, arready_a, rvalid_a, rready_a;
    logic [3:0]  araddr_a;
    logic [31:0] rdata_a;
    logic [1:0]  rresp_a;
    logic        tvalid_a, tready_a, tlast_a;
    logic [31:0] tdata_a;

    // DUT B: N=4, BASE=14
    logic        start_b, busy_b, done_b, err_b;
    logic [1:0]  err_idx_b;
    logic        arvalid_b, arready_b, rvalid_b, rready_b;
    logic [3:0]  araddr_b;
    logic [31:0] rdata_b;
    logic        tvalid_b, tlast_b;
    logic [31:0] tdata_b;

    // DUT C: N=1, DEPTH=1
    logic        start_c, busy_c, done_c, err_c;
    logic [0:0]  err_idx_c;
    logic        arvalid_c, arready_c, rvalid_c, rready_c;
    logic [3:0]  araddr_c;
    logic [31:0] rdata_c;
    logic        tvalid_c, tready_c, tlast_c;
    logic [31:0] tdata_c;

    axi_lite_burst_reader #(.N(NA), .DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE(BASE_A), .DEPTH(DEPTH_A)) u_dut_a (
        .ap_clk(clk), .ap_rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_idx(err_idx_a),
        .m_axi_ARVALID(arvalid_a), .m_axi_ARREADY(arready_a), .m_axi_ARADDR(araddr_a),
        .m_axi_RVALID(rvalid_a), .m_axi_RREADY(rready_a), .m_axi_RDATA(rdata_a), .m_axi_RRESP(rresp_a),
        .m_axis_TVALID(tvalid_a), .m_axis_TREADY(tready_a), .m_axis_TDATA(tdata_a), .m_axis_TLAST(tlast_a)
    );

    axi_lite_burst_reader #(.N(NB), .DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE(BASE_B), .DEPTH(2)) u_dut_b (
        .ap_clk(clk), .ap_rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_idx(err_idx_b),
        .m_axi_ARVALID(arvalid_b), .m_axi_ARREADY(arready_b), .m_axi_ARADDR(araddr_b),
        .m_axi_RVALID(rvalid_b), .m_axi_RREADY(rready_b), .m_axi_RDATA(rdata_b), .m_axi_RRESP(2'b00),
        .m_axis_TVALID(tvalid_b), .m_axis_TREADY(1'b1), .m_axis_TDATA(tdata_b), .m_axis_TLAST(tlast_b)
    );

    axi_lite_burst_reader #(.N(1), .DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE(0), .DEPTH(1)) u_dut_c (
        .ap_clk(clk), .ap_rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .err(err_c), .err_idx(err_idx_c),
        .m_axi_ARVALID(arvalid_c), .m_axi_ARREADY(arready_c), .m_axi_ARADDR(araddr_c),
        .m_axi_RVALID(rvalid_c), .m_axi_RREADY(rready_c), .m_axi_RDATA(rdata_c), .m_axi_RRESP(2'b00),
        .m_axis_TVALID(tvalid_c), .m_axis_TREADY(tready_c), .m_axis_TDATA(tdata_c), .m_axis_TLAST(tlast_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Scoreboard queues, filled by the stimulus side
    logic [31:0] exp_a[$];
    bit          exp_last_a[$];
    logic [31:0] exp_b[$];
    bit          exp_last_b[$];
    logic [3:0]  exp_addr_b[$];
    logic [31:0] exp_c[$];
    logic [3:0]  exp_addr_c[$];

    // Responder knobs for DUT A
    int          ar_pct = 100;
    int          rv_pct = 100;
    int          tr_low = 0;
    logic [15:0] err_mask_a = '0;

    // Responder A: in-order read-only memory, DATA = 0x1000_0000 + address
    int pend_a[$];
    bit rtaken_a;
    always @(negedge clk) begin
        if (rst) begin
            pend_a.delete();
            rtaken_a = 1'b0;
            arready_a = 1'b0;
            rvalid_a = 1'b0;
            rdata_a = '0;
            rresp_a = 2'b00;
            tready_a = 1'b0;
        end else begin
            if (rtaken_a) rvalid_a = 1'b0;
            arready_a = ($urandom_range(0, 99) < ar_pct);
            if (!rvalid_a && pend_a.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
                rvalid_a = 1'b1;
                rdata_a = 32'h1000_0000 + pend_a[0];
                rresp_a = err_mask_a[pend_a[0]] ? 2'b10 : 2'b00;
            end
            tready_a = ($urandom_range(0, 99) >= tr_low);
            #1;
            rtaken_a = rvalid_a && rready_a;
            if (rtaken_a) void'(pend_a.pop_front());
            if (arvalid_a && arready_a) pend_a.push_back(int'(araddr_a));
        end
    end

    // Responders B and C: one read outstanding, response the cycle after AR
    bit pv_b, rt_b, pv_c, rt_c;
    logic [3:0] pa_b, pa_c;
    always @(negedge clk) begin
        if (rst) begin
            pv_b = 0; rt_b = 0; pv_c = 0; rt_c = 0;
            arready_b = 0; rvalid_b = 0; rdata_b = '0;
            arready_c = 0; rvalid_c = 0; rdata_c = '0;
        end else begin
            if (rt_b) rvalid_b = 1'b0;
            if (rt_c) rvalid_c = 1'b0;
            arready_b = !pv_b && !rvalid_b;
            arready_c = !pv_c && !rvalid_c;
            if (pv_b && !rvalid_b) begin rvalid_b = 1'b1; rdata_b = 32'h2000_0000 + 32'(pa_b); end
            if (pv_c && !rvalid_c) begin rvalid_c = 1'b1; rdata_c = 32'h3000_0000 + 32'(pa_c); end
            #1;
            rt_b = rvalid_b && rready_b;
            if (rt_b) pv_b = 0;
            if (arvalid_b && arready_b) begin pv_b = 1; pa_b = araddr_b; end
            rt_c = rvalid_c && rready_c;
            if (rt_c) pv_c = 0;
            if (arvalid_c && arready_c) begin pv_c = 1; pa_c = araddr_c; end
        end
    end

    // Monitor A: pops the scoreboard on every accepted stream word
    int ar_hs_a, r_hs_a, pop_a, done_cnt_a;
    bit prev_arstall_a, prev_tstall_a, prev_tlast_a;
    logic [3:0]  prev_addr_a;
    logic [31:0] prev_tdata_a;
    always @(negedge clk) begin
        #2;
        if (rst || (start_a && !busy_a)) begin
            ar_hs_a = 0; r_hs_a = 0; pop_a = 0; done_cnt_a = 0;
            prev_arstall_a = 0; prev_tstall_a = 0;
        end else begin
            if (prev_arstall_a) begin
                check("a_arvalid_hold", arvalid_a, 1'b1);
                check("a_araddr_hold", araddr_a, prev_addr_a);
            end
            if (prev_tstall_a) begin
                check("a_tdata_hold", {tvalid_a, tlast_a, tdata_a}, {1'b1, prev_tlast_a, prev_tdata_a});
            end
            if (rready_a && (r_hs_a - pop_a) >= DEPTH_A) fail_now("a_rready_while_full");
            if (arvalid_a && arready_a) ar_hs_a++;
            if (rvalid_a && rready_a) r_hs_a++;
            if (tvalid_a && tready_a) begin
                pop_a++;
                if (exp_a.size() == 0) begin
                    fail_now("a_extra_beat");
                end else begin
                    check("a_tdata", tdata_a, exp_a.pop_front());
                    check("a_tlast_done", {tlast_a, done_a}, {2{exp_last_a.pop_front()}});
                end
            end else begin
                check("a_done_idle", done_a, 1'b0);
            end
            if (done_a) done_cnt_a++;
            if (ar_hs_a - pop_a > DEPTH_A) fail_now("a_outstanding_over_depth");
            prev_arstall_a = arvalid_a && !arready_a;
            prev_addr_a = araddr_a;
            prev_tstall_a = tvalid_a && !tready_a;
            prev_tdata_a = tdata_a;
            prev_tlast_a = tlast_a;
        end
    end

    // Monitor B/C
    int done_cnt_b, done_cnt_c;
    bit prev_tstall_c;
    logic [31:0] prev_tdata_c;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            done_cnt_b = 0; done_cnt_c = 0; prev_tstall_c = 0;
        end else begin
            if (start_b && !busy_b) done_cnt_b = 0;
            if (start_c && !busy_c) done_cnt_c = 0;
            if (arvalid_b && arready_b) begin
                if (exp_addr_b.size() == 0) fail_now("b_extra_ar");
                else check("b_araddr", araddr_b, exp_addr_b.pop_front());
            end
            if (tvalid_b) begin
                if (exp_b.size() == 0) fail_now("b_extra_beat");
                else begin
                    check("b_tdata", tdata_b, exp_b.pop_front());
                    check("b_tlast_done", {tlast_b, done_b}, {2{exp_last_b.pop_front()}});
                end
            end
            if (done_b) done_cnt_b++;
            if (arvalid_c && arready_c) begin
                if (exp_addr_c.size() == 0) fail_now("c_extra_ar");
                else check("c_araddr", araddr_c, exp_addr_c.pop_front());
            end
            if (prev_tstall_c) check("c_tdata_hold", {tvalid_c, tlast_c, tdata_c}, {2'b11, prev_tdata_c});
            if (tvalid_c && tready_c) begin
                if (exp_c.size() == 0) fail_now("c_extra_beat");
                else check("c_beat", {tlast_c, done_c, tdata_c}, {2'b11, exp_c.pop_front()});
            end
            if (done_c) done_cnt_c++;
            prev_tstall_c = tvalid_c && !tready_c;
            prev_tdata_c = tdata_c;
        end
    end

    task automatic check_a_zero(input string name);
        check(name, {busy_a, done_a, err_a, err_idx_a, arvalid_a, araddr_a, rready_a,
                     tvalid_a, tdata_a, tlast_a}, 47'h0);
    endtask

    task automatic run_a(input int arp, input int rvp, input int trl, input logic [15:0] mask,
                         input bit poke, input int rst_at);
        bit          e_err;
        logic [3:0]  e_idx;
        ar_pct = arp; rv_pct = rvp; tr_low = trl; err_mask_a = mask;
        e_err = 0; e_idx = '0;
        @(negedge clk);
        check("a_idle_before_start", busy_a, 1'b0);
        for (int i = 0; i < NA; i++) begin
            exp_a.push_back(32'h1000_0000 + 32'((BASE_A + i) % 16));
            exp_last_a.push_back(i == NA - 1);
            if (mask[(BASE_A + i) % 16] && !e_err) begin e_err = 1; e_idx = 4'(i); end
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_err_after_start", {busy_a, err_a, err_idx_a}, {1'b1, 1'b0, 4'h0});
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (poke) start_a = (c == 3);
            if (rst_at >= 0 && pop_a >= rst_at) begin
                #3 rst = 1'b1;
                #1 check_a_zero("a_async_reset_outputs");
                exp_a.delete();
                exp_last_a.delete();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (exp_a.size() == 0 && !busy_a) break;
        end
        start_a = 1'b0;
        check("a_run_complete", {32'(exp_a.size()), busy_a}, 33'h0);
        check("a_done_pulses", done_cnt_a, 1);
        check("a_err", {err_a, err_idx_a}, {e_err, e_idx});
    endtask

    initial begin
        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0; tready_c = 0;
        repeat (3) @(negedge clk);
        #1 check_a_zero("a_reset_outputs");
        check("c_reset_outputs", {busy_c, done_c, err_c, arvalid_c, araddr_c, rready_c, tvalid_c, tdata_c, tlast_c}, 42'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_a_zero("a_after_release");

        // Directed clean run, then randomized stalls
        run_a(100, 100, 0, 16'h0, 0, -1);
        for (int k = 0; k < 3; k++) run_a(60, 50, 30, 16'h0, 0, -1);

        // Error responses on words 3 and 6, then a clean run clears err
        run_a(70, 60, 30, 16'h0048, 0, -1);
        run_a(100, 100, 0, 16'h0, 0, -1);

        // BASE=14 wrap-around
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            exp_b.push_back(32'h2000_0000 + 32'((BASE_B + i) % 16));
            exp_last_b.push_back(i == NB - 1);
            exp_addr_b.push_back(4'((BASE_B + i) % 16));
        end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 200 && (exp_b.size() > 0 || busy_b); c++) @(negedge clk);
        check("b_run_complete", {32'(exp_b.size()), 32'(exp_addr_b.size()), busy_b}, 65'h0);
        check("b_done_err", {32'(done_cnt_b), err_b}, {32'd1, 1'b0});

        // Start while busy, reset mid-run at word 5, then a clean run
        run_a(100, 100, 0, 16'h0, 1, -1);
        run_a(80, 80, 20, 16'h0, 0, 5);
        run_a(100, 100, 0, 16'h0, 0, -1);

        // N=1, DEPTH=1 with the stream stalled
        @(negedge clk);
        exp_c.push_back(32'h3000_0000);
        exp_addr_c.push_back(4'h0);
        tready_c = 1'b0;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (8) @(negedge clk);
        check("c_stalled_valid", {tvalid_c, busy_c}, 2'b11);
        tready_c = 1'b1;
        for (int c = 0; c < 200 && (exp_c.size() > 0 || busy_c); c++) @(negedge clk);
        check("c_run_complete", {32'(exp_c.size()), 32'(exp_addr_c.size()), busy_c}, 65'h0);
        check("c_done_pulses", done_cnt_c, 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
